ff_bank: RTL and testbench
==========================

# ff_bank

Parametrised bank of WIDTH independent storage cells, each acting as an SR, JK, D or T flip-flop according to a shared mode input. It replaces single-bit SR storage in the control path. Key differences from that storage:
- a defined, configurable policy for S=R=1 instead of an undriven result;
- per-channel enables and a synchronous clear;
- change pulses for downstream edge logic;
- conflict monitoring, as a sticky error flag and a saturating counter.

## Interface
Parameters:
- WIDTH, 8, number of channels (1..64)
- SR_POLICY, 0, SR-mode action on S=R=1: 0 hold, 1 set-dominant, 2 reset-dominant, 3 toggle
- CNT_W, 8, width of conflict counter (2..16)

Ports:
- clk  in  1  clock, all state updates on rising edge
- n_rst  in  1  asynchronous, active-low reset
- mode  in  2  cell function for all channels: 00 SR, 01 JK, 10 D, 11 T
- en  in  WIDTH  per-channel update enable
- a  in  WIDTH  per-channel S / J / D / T input
- b  in  WIDTH  per-channel R / K input; ignored in D and T modes
- clr  in  1  synchronous clear of q, overrides en/a/b
- err_clr  in  1  synchronous clear of err and err_cnt
- q  out  WIDTH  cell state
- qn  out  WIDTH  ~q, combinational
- q_chg  out  WIDTH  registered one-cycle pulse: channel q changed on the previous edge
- err  out  1  sticky: a conflict has occurred since the last reset or clear
- err_cnt  out  CNT_W  saturating count of cycles containing at least one conflict

## Operation
- Reset values: q=0, qn=all ones, q_chg=0, err=0, err_cnt=0.
- Per channel, next state on each edge, with clr=0 and en[i]=1:
  - SR: 00 hold, S=1 R=0 → 1, S=0 R=1 → 0, 11 → per SR_POLICY.
  - JK: 00 hold, 10 → 1, 01 → 0, 11 → toggle.
  - D: q=a[i].
  - T: a[i]=1 toggles, a[i]=0 holds.
- en[i]=0: channel holds regardless of mode.
- clr=1: q=0 for all channels. q_chg reflects the channels that were 1.
- Conflict, defined per channel: mode=SR, en[i]=1, clr=0, a[i]=b[i]=1. JK 11 is never a conflict.
- A conflict is flagged and counted under every SR_POLICY, including hold.
- In any cycle with at least one conflicting channel:
  - err is set to 1;
  - err_cnt increments by 1, regardless of how many channels conflict;
  - err_cnt saturates at 2^CNT_W−1 and never wraps.
- err_clr=1 in the same cycle as a conflict: clear wins, so err=0 and err_cnt=0 after the edge.
- A mode change takes effect on the same edge at which the new mode is sampled. No internal mode register exists.
- q_chg[i] = q_next[i] XOR q[i], registered alongside q.

## Timing
- Latency from inputs to q is one clock edge. qn tracks q combinationally.
- q_chg asserts in the cycle immediately after the edge that changed q, for exactly one cycle per change.
- err and err_cnt update on the same edge as the offending cycle's q update.
- Assertion of n_rst at any time forces the reset values immediately, including mid-toggle and during counter saturation.
- Deassertion of n_rst is expected to be synchronised upstream. The first functional edge is the first rising edge with n_rst=1.
- No combinational path from inputs to outputs other than q→qn.

## Structure
- Package ff_bank_pkg holds:
  - the mode encodings MODE_SR, MODE_JK, MODE_D, MODE_T;
  - the policy constants POL_HOLD, POL_SET, POL_RST, POL_TGL.
- Sub-module ff_cell:
  - one channel: next-state function, q register and q_chg register;
  - outputs a conflict bit.
- ff_bank:
  - instantiates WIDTH ff_cell in a generate loop;
  - ORs the conflict bits;
  - owns err and err_cnt.

## Test plan
- Reset and SR basics: WIDTH=8, SR mode, en=FF, a=0F, b=F0 → q=0F, q_chg=0F the next cycle, err=0. Then a=b=0 → q holds 0F, q_chg=00.
- SR conflict policy: bench each SR_POLICY=0/1/2/3.
  - Stimulus: q=0F, a=b=FF, en=FF, one cycle.
  - Required q: 0F / FF / 00 / F0 respectively.
  - Every policy: err=1, err_cnt=1.
- JK/D/T with enables:
  - JK, q=00, a=b=FF, en=55 → q=55; second cycle → q=00.
  - D, a=A5, en=0F → q=05.
  - T, a=FF for 3 cycles, en=01 → q[0] 0→1→0→1.
- Counter saturation and clear:
  - CNT_W=2, conflicts held 5 cycles → err_cnt 1,2,3,3,3.
  - err_clr asserted together with a conflict → err=0, err_cnt=0.
  - A subsequent conflict alone → err_cnt=1.
- Clear priority: q=FF, clr=1 with en=FF, D mode, a=FF → q=00, q_chg=FF the next cycle, no conflict counted.
- Async reset mid-operation: T mode toggling, err_cnt=3, n_rst pulsed low mid-cycle.
  - During the pulse, before the next edge: q=00, q_chg=00, err=0, err_cnt=0.
  - After release: toggling resumes from 0.

Source files
------------

// File: rtl/ff_bank_pkg.sv
// Shared encodings for the ff_bank storage cells: cell function selection
// and the action taken on S=R=1 in SR mode.
package ff_bank_pkg;

  // Cell function, shared by every channel of the bank
  typedef enum logic [1:0] {
    MODE_SR = 2'b00,
    MODE_JK = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } mode_e;

  // SR-mode behaviour when both S and R are asserted
  localparam int POL_HOLD = 0;
  localparam int POL_SET  = 1;
  localparam int POL_RST  = 2;
  localparam int POL_TGL  = 3;

endpackage

// File: rtl/ff_cell.sv
// One storage channel: next-state function for SR/JK/D/T, the q register
// and the registered change pulse. Reports an SR conflict (S=R=1 while
// enabled and not being cleared) so the bank can monitor it.
module ff_cell
  import ff_bank_pkg::*;
#(
  parameter int SR_POLICY = POL_HOLD
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [1:0] mode,
  input  logic       en,
  input  logic       a,
  input  logic       b,
  input  logic       clr,
  output logic       q,
  output logic       q_chg,
  output logic       conflict
);

  logic q_next;

  // Next-state and conflict decode; clear overrides everything, a disabled
  // channel holds whatever the mode
  always_comb begin
    q_next   = q;
    conflict = 1'b0;
    if (clr) begin
      q_next = 1'b0;
    end else if (en) begin
      case (mode)
        MODE_SR: begin
          case ({a, b})
            2'b10:   q_next = 1'b1;
            2'b01:   q_next = 1'b0;
            2'b11: begin
              conflict = 1'b1;
              case (SR_POLICY)
                POL_SET: q_next = 1'b1;
                POL_RST: q_next = 1'b0;
                POL_TGL: q_next = ~q;
                default: q_next = q;
              endcase
            end
            default: q_next = q;
          endcase
        end
        MODE_JK: begin
          case ({a, b})
            2'b10:   q_next = 1'b1;
            2'b01:   q_next = 1'b0;
            2'b11:   q_next = ~q;
            default: q_next = q;
          endcase
        end
        MODE_D:  q_next = a;
        MODE_T:  q_next = a ? ~q : q;
        default: q_next = q;
      endcase
    end
  end

  // State register plus a one-cycle pulse marking that q just changed
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      q     <= 1'b0;
      q_chg <= 1'b0;
    end else begin
      q     <= q_next;
      q_chg <= q_next ^ q;
    end
  end

endmodule

// File: rtl/ff_bank.sv
// Bank of WIDTH independent flip-flop channels sharing one mode select,
// with per-channel enables, synchronous clear, change pulses and SR
// conflict monitoring (sticky flag plus saturating cycle counter).
module ff_bank
  import ff_bank_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SR_POLICY = POL_HOLD,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic [WIDTH-1:0] q_chg,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] conflict;
  logic             any_conflict;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_cell #(
      .SR_POLICY (SR_POLICY)
    ) u_cell (
      .clk      (clk),
      .n_rst    (n_rst),
      .mode     (mode),
      .en       (en[i]),
      .a        (a[i]),
      .b        (b[i]),
      .clr      (clr),
      .q        (q[i]),
      .q_chg    (q_chg[i]),
      .conflict (conflict[i])
    );
  end

  // A cycle counts once no matter how many channels conflict
  always_comb begin
    any_conflict = |conflict;
    qn           = ~q;
  end

  // Sticky error flag and saturating conflict-cycle counter; clear wins
  // over a simultaneous conflict
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else if (err_clr) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else if (any_conflict) begin
      err <= 1'b1;
      if (err_cnt != CNT_MAX) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ff_bank.sv
// Directed bench for ff_bank: one bank per SR policy sharing the same
// stimulus, 2-bit conflict counters so saturation is reachable quickly.
module tb_ff_bank;

  localparam int W  = 8;
  localparam int CW = 2;

  logic          clk;
  logic          n_rst;
  logic [1:0]    mode;
  logic [W-1:0]  en, a, b;
  logic          clr, err_clr;

  logic [W-1:0]  q0, qn0, qc0, q1, qn1, qc1, q2, qn2, qc2, q3, qn3, qc3;
  logic          e0, e1, e2, e3;
  logic [CW-1:0] c0, c1, c2, c3;

  int n_vec;
  int n_err;
  logic [CW-1:0] exp_q[$];

  ff_bank #(.WIDTH(W), .SR_POLICY(0), .CNT_W(CW)) u_p0 (
    .clk(clk), .n_rst(n_rst), .mode(mode), .en(en), .a(a), .b(b),
    .clr(clr), .err_clr(err_clr), .q(q0), .qn(qn0), .q_chg(qc0),
    .err(e0), .err_cnt(c0));
  ff_bank #(.WIDTH(W), .SR_POLICY(1), .CNT_W(CW)) u_p1 (
    .clk(clk), .n_rst(n_rst), .mode(mode), .en(en), .a(a), .b(b),
    .clr(clr), .err_clr(err_clr), .q(q1), .qn(qn1), .q_chg(qc1),
    .err(e1), .err_cnt(c1));
  ff_bank #(.WIDTH(W), .SR_POLICY(2), .CNT_W(CW)) u_p2 (
    .clk(clk), .n_rst(n_rst), .mode(mode), .en(en), .a(a), .b(b),
    .clr(clr), .err_clr(err_clr), .q(q2), .qn(qn2), .q_chg(qc2),
    .err(e2), .err_cnt(c2));
  ff_bank #(.WIDTH(W), .SR_POLICY(3), .CNT_W(CW)) u_p3 (
    .clk(clk), .n_rst(n_rst), .mode(mode), .en(en), .a(a), .b(b),
    .clr(clr), .err_clr(err_clr), .q(q3), .qn(qn3), .q_chg(qc3),
    .err(e3), .err_cnt(c3));

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive all shared inputs
  task automatic drive(input logic [1:0] m, input logic [W-1:0] e,
                       input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic c, input logic ec);
    mode = m; en = e; a = va; b = vb; clr = c; err_clr = ec;
  endtask

  // Advance one edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    n_rst = 1'b0;
    drive(2'b00, '0, '0, '0, 1'b0, 1'b0);
    #2;
    check_vec("rst_q",   q0,  8'h00);
    check_vec("rst_qn",  qn0, 8'hFF);
    check_vec("rst_chg", qc0, 8'h00);
    check_vec("rst_err", e0,  1'b0);
    check_vec("rst_cnt", c0,  2'd0);
    @(negedge clk);
    n_rst = 1'b1;

    // SR basics
    drive(2'b00, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0);
    step();
    check_vec("sr_set_q",   q0,  8'h0F);
    check_vec("sr_set_qn",  qn0, 8'hF0);
    check_vec("sr_set_chg", qc0, 8'h0F);
    check_vec("sr_set_err", e0,  1'b0);
    drive(2'b00, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0);
    step();
    check_vec("sr_hold_q",   q0,  8'h0F);
    check_vec("sr_hold_chg", qc0, 8'h00);

    // SR conflict under each policy
    drive(2'b00, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    step();
    check_vec("pol_hold_q", q0, 8'h0F);
    check_vec("pol_set_q",  q1, 8'hFF);
    check_vec("pol_rst_q",  q2, 8'h00);
    check_vec("pol_tgl_q",  q3, 8'hF0);
    check_vec("pol_tgl_chg", qc3, 8'hFF);
    check_vec("pol0_err", e0, 1'b1);
    check_vec("pol1_err", e1, 1'b1);
    check_vec("pol2_err", e2, 1'b1);
    check_vec("pol3_err", e3, 1'b1);
    check_vec("pol0_cnt", c0, 2'd1);
    check_vec("pol1_cnt", c1, 2'd1);
    check_vec("pol2_cnt", c2, 2'd1);
    check_vec("pol3_cnt", c3, 2'd1);

    // Clear error state, then clear q
    drive(2'b00, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b1);
    step();
    check_vec("errclr_err", e0, 1'b0);
    check_vec("errclr_cnt", c0, 2'd0);
    drive(2'b00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    step();
    check_vec("clr_q",   q0,  8'h00);
    check_vec("clr_chg", qc0, 8'h0F);

    // JK with enables; 11 toggles and is not a conflict
    drive(2'b01, 8'h55, 8'hFF, 8'hFF, 1'b0, 1'b0);
    step();
    check_vec("jk_t1_q",   q0, 8'h55);
    check_vec("jk_t1_err", e0, 1'b0);
    step();
    check_vec("jk_t2_q",   q0,  8'h00);
    check_vec("jk_t2_chg", qc0, 8'h55);
    check_vec("jk_t2_cnt", c0,  2'd0);
    drive(2'b01, 8'hFF, 8'hF0, 8'h0F, 1'b0, 1'b0);
    step();
    check_vec("jk_setrst_q", q0, 8'hF0);

    // D with enables: only low nibble follows a
    drive(2'b10, 8'h0F, 8'hA5, 8'hFF, 1'b0, 1'b0);
    step();
    check_vec("d_en_q", q0, 8'hF5);
    drive(2'b10, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0);
    step();
    check_vec("d_zero_q", q0, 8'h00);
    drive(2'b10, 8'h0F, 8'hA5, 8'h00, 1'b0, 1'b0);
    step();
    check_vec("d_a5_q", q0, 8'h05);
    drive(2'b10, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0);
    step();

    // T with channel 0 enabled only
    drive(2'b11, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0);
    step();
    check_vec("t_c1_q", q0, 8'h01);
    check_vec("t_c1_chg", qc0, 8'h01);
    step();
    check_vec("t_c2_q", q0, 8'h00);
    step();
    check_vec("t_c3_q", q0, 8'h01);

    // Counter saturation at 3
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd3);
    drive(2'b00, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      step();
      check_vec("sat_cnt", c0, exp_q.pop_front());
      check_vec("sat_err", e0, 1'b1);
    end

    // err_clr wins over a simultaneous conflict
    drive(2'b00, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b1);
    step();
    check_vec("clrwin_err", e0, 1'b0);
    check_vec("clrwin_cnt", c0, 2'd0);
    drive(2'b00, 8'h01, 8'h01, 8'h01, 1'b0, 1'b0);
    step();
    check_vec("after_clr_cnt", c0, 2'd1);
    check_vec("after_clr_err", e0, 1'b1);

    // Clear priority over D loading
    drive(2'b10, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);
    step();
    check_vec("d_ff_q", q0, 8'hFF);
    drive(2'b10, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0);
    step();
    check_vec("clrpri_q",   q0,  8'h00);
    check_vec("clrpri_chg", qc0, 8'hFF);
    check_vec("clrpri_cnt", c0,  2'd1);
    drive(2'b00, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0);
    step();
    check_vec("clr_sr_nocnt", c0, 2'd1);
    check_vec("clr_sr_q1",    q1, 8'h00);

    // Reach err_cnt=3, then toggle and reset asynchronously mid-cycle
    drive(2'b00, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    step();
    step();
    check_vec("pre_rst_cnt", c0, 2'd3);
    drive(2'b11, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);
    step();
    check_vec("pre_rst_t_q", q0, 8'hFF);
    #2;
    n_rst = 1'b0;
    #1;
    check_vec("arst_q",   q0,  8'h00);
    check_vec("arst_qn",  qn0, 8'hFF);
    check_vec("arst_chg", qc0, 8'h00);
    check_vec("arst_err", e0,  1'b0);
    check_vec("arst_cnt", c0,  2'd0);
    #1;
    n_rst = 1'b1;
    step();
    check_vec("resume_q",   q0,  8'hFF);
    check_vec("resume_chg", qc0, 8'hFF);
    step();
    check_vec("resume2_q", q0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
